ddr3_cmd_sequencer: RTL and testbench

Command-side front end that drives the DDR3 device's control pins in the verification environment. It accepts single-burst read/write requests from the bus agent over a valid/ready handshake and opens the row with ACTIVATE. It then issues READ or WRITE (BL8, no auto-precharge), closes the row with PRECHARGE under a closed-page policy, and inserts periodic REFRESH. It sits directly upstream of the DDR3 device model and owns all command timing; the data path (dq/dqs) is out of scope.

---
 rtl/ddr3_ctrl_pkg.sv | 48 ++++
 rtl/ddr3_refresh_timer.sv | 38 +++
 rtl/ddr3_cmd_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_ddr3_cmd_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_ctrl_pkg.sv
// Shared DDR3 command encodings, sequencer states and default timing.
// Also used by the DDR3 device model.
package ddr3_ctrl_pkg;

    // {cs_n, ras_n, cas_n, we_n}; DES is the idle value of the pins while in reset
    typedef enum logic [3:0] {
        CMD_DES = 4'b1111,
        CMD_NOP = 4'b0111,
        CMD_ACT = 4'b0011,
        CMD_RD  = 4'b0101,
        CMD_WR  = 4'b0100,
        CMD_PRE = 4'b0010,
        CMD_REF = 4'b0001
    } cmd_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACT,
        S_WAIT_RCD,
        S_RW,
        S_WAIT_DATA,
        S_WAIT_PRE,
        S_PRE,
        S_WAIT_RP,
        S_REF,
        S_WAIT_RFC
    } state_e;

    localparam int DEF_ROW_W  = 14;
    localparam int DEF_COL_W  = 10;
    localparam int DEF_BA_W   = 3;
    localparam int DEF_T_RCD  = 6;
    localparam int DEF_T_RAS  = 15;
    localparam int DEF_T_RP   = 6;
    localparam int DEF_T_CL   = 6;
    localparam int DEF_T_CWL  = 5;
    localparam int DEF_T_WR   = 6;
    localparam int DEF_T_REFI = 780;
    localparam int DEF_T_RFC  = 44;

    localparam int A10_BIT = 10;
    localparam int A12_BIT = 12;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr3_refresh_timer.sv
// Free-running refresh interval counter with a single-entry pending flag.
module ddr3_refresh_timer
    import ddr3_ctrl_pkg::*;
#(
    parameter int T_REFI = DEF_T_REFI
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ref_ack,
    output logic ref_pending,
    output logic ref_wrap
);

    localparam int CW = $clog2(T_REFI) + 1;
    localparam logic [CW-1:0] LAST = CW'(T_REFI - 1);

    logic [CW-1:0] r_cnt;
    logic          r_pend;

    assign ref_wrap    = (r_cnt == LAST);
    assign ref_pending = r_pend;

    // ack wins over a coincident wrap: at most one refresh is ever owed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_pend <= 1'b0;
        end else begin
            r_cnt <= ref_wrap ? '0 : r_cnt + 1'b1;
            if (ref_ack) begin
                r_pend <= 1'b0;
            end else if (ref_wrap) begin
                r_pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr3_cmd_sequencer.sv
// Closed-page DDR3 command sequencer: ACT, BL8 RD/WR, PRE and periodic REF.
// Command pins are registered from the state being entered.
module ddr3_cmd_sequencer
    import ddr3_ctrl_pkg::*;
#(
    parameter int ROW_W  = DEF_ROW_W,
    parameter int COL_W  = DEF_COL_W,
    parameter int BA_W   = DEF_BA_W,
    parameter int T_RCD  = DEF_T_RCD,
    parameter int T_RAS  = DEF_T_RAS,
    parameter int T_RP   = DEF_T_RP,
    parameter int T_CL   = DEF_T_CL,
    parameter int T_CWL  = DEF_T_CWL,
    parameter int T_WR   = DEF_T_WR,
    parameter int T_REFI = DEF_T_REFI,
    parameter int T_RFC  = DEF_T_RFC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [BA_W-1:0]  req_ba,
    input  logic [ROW_W-1:0] req_row,
    input  logic [COL_W-1:0] req_col,
    output logic             done,
    output logic             done_we,
    output logic             cs_n,
    output logic             ras_n,
    output logic             cas_n,
    output logic             we_n,
    output logic [BA_W-1:0]  ba,
    output logic [ROW_W-1:0] addr,
    output logic             busy
);

    // Data window and PRE offsets, both measured from the RD/WR cycle
    localparam int D_RD  = T_CL + 4;
    localparam int D_WR  = T_CWL + 4;
    localparam int P_RD  = imax(T_RAS - T_RCD, D_RD);
    localparam int P_WR  = imax(T_RAS - T_RCD, D_WR + T_WR);
    localparam int T_MAX = imax(imax(imax(T_RCD, T_RAS), imax(T_RP, T_RFC)),
                                imax(P_RD, P_WR));
    localparam int CNT_W = $clog2(T_MAX) + 1;

    // A wait state of k cycles loads k-1 and leaves when the counter is 0
    localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(T_RCD - 2);
    localparam logic [CNT_W-1:0] LD_DRD = CNT_W'(D_RD - 2);
    localparam logic [CNT_W-1:0] LD_DWR = CNT_W'(D_WR - 2);
    localparam logic [CNT_W-1:0] LD_GRD = CNT_W'(imax(P_RD - D_RD - 1, 0));
    localparam logic [CNT_W-1:0] LD_GWR = CNT_W'(imax(P_WR - D_WR - 1, 0));
    localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(T_RP - 2);
    localparam logic [CNT_W-1:0] LD_RFC = CNT_W'(T_RFC - 2);
    localparam bit GAP_RD = (P_RD > D_RD);
    localparam bit GAP_WR = (P_WR > D_WR);

    state_e           r_state;
    state_e           w_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_ld;
    logic [CNT_W-1:0] w_ld_val;
    logic             w_cnt_z;
    cmd_e             r_cmd;
    cmd_e             w_cmd;
    logic [BA_W-1:0]  r_ba;
    logic [BA_W-1:0]  w_ba;
    logic [ROW_W-1:0] r_addr;
    logic [ROW_W-1:0] w_addr;
    logic             r_ready;
    logic             r_done;
    logic             r_done_we;
    logic             w_done;
    logic             r_we;
    logic [BA_W-1:0]  r_bank;
    logic [COL_W-1:0] r_col;
    logic             w_cap;
    logic             w_ack;
    logic             w_pend;
    logic             w_wrap;
    logic             w_pend_nxt;
    logic             w_gap;

    ddr3_refresh_timer #(
        .T_REFI(T_REFI)
    ) u_ref (
        .clk        (clk),
        .rst_n      (rst_n),
        .ref_ack    (w_ack),
        .ref_pending(w_pend),
        .ref_wrap   (w_wrap)
    );

    assign w_cnt_z    = (r_cnt == '0);
    assign w_gap      = r_we ? GAP_WR : GAP_RD;
    assign w_pend_nxt = w_ack ? 1'b0 : (w_pend | w_wrap);

    always_comb begin
        w_nxt    = r_state;
        w_cmd    = CMD_NOP;
        w_ba     = r_ba;
        w_addr   = r_addr;
        w_ld     = 1'b0;
        w_ld_val = '0;
        w_ack    = 1'b0;
        w_cap    = 1'b0;
        w_done   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_pend) begin
                    w_nxt = S_REF;
                    w_cmd = CMD_REF;
                    w_ack = 1'b1;
                end else if (req_valid && r_ready) begin
                    w_nxt  = S_ACT;
                    w_cmd  = CMD_ACT;
                    w_ba   = req_ba;
                    w_addr = req_row;
                    w_cap  = 1'b1;
                end
            end
            S_ACT: begin
                w_nxt    = S_WAIT_RCD;
                w_ld     = 1'b1;
                w_ld_val = LD_RCD;
            end
            S_WAIT_RCD: begin
                if (w_cnt_z) begin
                    w_nxt           = S_RW;
                    w_cmd           = r_we ? CMD_WR : CMD_RD;
                    w_ba            = r_bank;
                    w_addr          = ROW_W'(r_col);
                    w_addr[A10_BIT] = 1'b0;
                    w_addr[A12_BIT] = 1'b1;
                end
            end
            S_RW: begin
                w_nxt    = S_WAIT_DATA;
                w_ld     = 1'b1;
                w_ld_val = r_we ? LD_DWR : LD_DRD;
            end
            S_WAIT_DATA: begin
                if (w_cnt_z) begin
                    w_done = 1'b1;
                    if (w_gap) begin
                        w_nxt    = S_WAIT_PRE;
                        w_ld     = 1'b1;
                        w_ld_val = r_we ? LD_GWR : LD_GRD;
                    end else begin
                        w_nxt           = S_PRE;
                        w_cmd           = CMD_PRE;
                        w_ba            = r_bank;
                        w_addr[A10_BIT] = 1'b0;
                    end
                end
            end
            S_WAIT_PRE: begin
                if (w_cnt_z) begin
                    w_nxt           = S_PRE;
                    w_cmd           = CMD_PRE;
                    w_ba            = r_bank;
                    w_addr[A10_BIT] = 1'b0;
                end
            end
            S_PRE: begin
                w_nxt    = S_WAIT_RP;
                w_ld     = 1'b1;
                w_ld_val = LD_RP;
            end
            S_WAIT_RP: begin
                if (w_cnt_z) begin
                    w_nxt = S_IDLE;
                end
            end
            S_REF: begin
                w_nxt    = S_WAIT_RFC;
                w_ld     = 1'b1;
                w_ld_val = LD_RFC;
            end
            S_WAIT_RFC: begin
                if (w_cnt_z) begin
                    w_nxt = S_IDLE;
                end
            end
            default: begin
                w_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_ld) begin
                r_cnt <= w_ld_val;
            end else if (!w_cnt_z) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we   <= 1'b0;
            r_bank <= '0;
            r_col  <= '0;
        end else if (w_cap) begin
            r_we   <= req_we;
            r_bank <= req_ba;
            r_col  <= req_col;
        end
    end

    // Ready looks one cycle ahead so a refresh owed on IDLE entry blocks it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd     <= CMD_DES;
            r_ba      <= '0;
            r_addr    <= '0;
            r_ready   <= 1'b0;
            r_done    <= 1'b0;
            r_done_we <= 1'b0;
        end else begin
            r_cmd     <= w_cmd;
            r_ba      <= w_ba;
            r_addr    <= w_addr;
            r_ready   <= (w_nxt == S_IDLE) && !w_pend_nxt;
            r_done    <= w_done;
            r_done_we <= w_done & r_we;
        end
    end

    assign {cs_n, ras_n, cas_n, we_n} = r_cmd;
    assign ba        = r_ba;
    assign addr      = r_addr;
    assign req_ready = r_ready;
    assign done      = r_done;
    assign done_we   = r_done_we;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_ddr3_cmd_sequencer.sv
// Directed bench for ddr3_cmd_sequencer: burst timing table, T_RAS bound,
// refresh priority/saturation and asynchronous reset mid-burst.
module tb_ddr3_cmd_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rst_r_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_ba;
    logic [13:0] req_row;
    logic [9:0]  req_col;
    logic        vld_r;

    logic [3:0]  d_cmd, c_cmd, f_cmd, g_cmd;
    logic [2:0]  d_ba, c_ba, f_ba, g_ba;
    logic [13:0] d_addr, c_addr, f_addr, g_addr;
    logic        d_rdy, c_rdy, f_rdy, g_rdy;
    logic        d_done, c_done, f_done, g_done;
    logic        d_dwe, c_dwe, f_dwe, g_dwe;
    logic        d_busy, c_busy, f_busy, g_busy;

    ddr3_cmd_sequencer u_def (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(d_rdy),
        .req_we(req_we), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
        .done(d_done), .done_we(d_dwe), .cs_n(d_cmd[3]), .ras_n(d_cmd[2]),
        .cas_n(d_cmd[1]), .we_n(d_cmd[0]), .ba(d_ba), .addr(d_addr), .busy(d_busy)
    );

    ddr3_cmd_sequencer #(.T_CL(3)) u_cl3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(c_rdy),
        .req_we(req_we), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
        .done(c_done), .done_we(c_dwe), .cs_n(c_cmd[3]), .ras_n(c_cmd[2]),
        .cas_n(c_cmd[1]), .we_n(c_cmd[0]), .ba(c_ba), .addr(c_addr), .busy(c_busy)
    );

    ddr3_cmd_sequencer #(.T_REFI(40)) u_r40 (
        .clk(clk), .rst_n(rst_r_n), .req_valid(vld_r), .req_ready(f_rdy),
        .req_we(1'b0), .req_ba(3'd1), .req_row(14'd5), .req_col(10'd8),
        .done(f_done), .done_we(f_dwe), .cs_n(f_cmd[3]), .ras_n(f_cmd[2]),
        .cas_n(f_cmd[1]), .we_n(f_cmd[0]), .ba(f_ba), .addr(f_addr), .busy(f_busy)
    );

    ddr3_cmd_sequencer #(.T_REFI(10)) u_r10 (
        .clk(clk), .rst_n(rst_r_n), .req_valid(vld_r), .req_ready(g_rdy),
        .req_we(1'b0), .req_ba(3'd1), .req_row(14'd5), .req_col(10'd8),
        .done(g_done), .done_we(g_dwe), .cs_n(g_cmd[3]), .ras_n(g_cmd[2]),
        .cas_n(g_cmd[1]), .we_n(g_cmd[0]), .ba(g_ba), .addr(g_addr), .busy(g_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, got, got, exp, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  ba;
        logic [13:0] row;
        logic [9:0]  col;
        int          rw_addr;
        int          act;
        int          rw;
        int          dn;
        int          pre;
        int          rdy;
        int          c_dn;
        int          c_pre;
        int          c_rdy;
    } vec_t;

    vec_t tbl[4];

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_reset_pins(input string tag);
        chk({tag, "_cmd"}, 32'(d_cmd), 32'hF);
        chk({tag, "_ba"}, 32'(d_ba), 0);
        chk({tag, "_addr"}, 32'(d_addr), 0);
        chk({tag, "_rdy"}, 32'(d_rdy), 0);
        chk({tag, "_done"}, 32'(d_done), 0);
        chk({tag, "_dwe"}, 32'(d_dwe), 0);
        chk({tag, "_busy"}, 32'(d_busy), 0);
    endtask

    initial begin
        int a_act, a_act_ba, a_act_addr, a_rw, a_rw_cmd, a_rw_addr;
        int a_dn, a_dwe, a_pre, a_pre_ba, a_rdy, n_act, n_dn;
        int c_dn_k, c_pre_k, c_rdy_k;
        int idle_n;
        int r40_act[$];
        int r40_ref[$];
        int r10_ref[$];
        int r40_viol, r40_last, r10_gap_bad, r10_idle, r10_act_n;

        rst_n     = 1'b0;
        rst_r_n   = 1'b0;
        vld_r     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_ba    = '0;
        req_row   = '0;
        req_col   = '0;

        tbl[0] = '{1'b0, 3'd2, 14'h1A5, 10'h040, 'h1040, 1, 7, 17, 17, 23, 14, 16, 22};
        tbl[1] = '{1'b1, 3'd2, 14'h1A5, 10'h040, 'h1040, 1, 7, 16, 22, 28, 16, 22, 28};
        tbl[2] = '{1'b0, 3'd7, 14'h3FFF, 10'h3FF, 'h13FF, 1, 7, 17, 17, 23, 14, 16, 22};
        tbl[3] = '{1'b1, 3'd0, 14'h0000, 10'h000, 'h1000, 1, 7, 16, 22, 28, 16, 22, 28};

        for (int v = 0; v < 4; v++) begin
            rst_n     = 1'b0;
            req_valid = 1'b0;
            @(negedge clk);
            check_reset_pins($sformatf("v%0d_rst", v));
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk($sformatf("v%0d_rdy_after_rst", v), 32'(d_rdy), 1);
            req_valid = 1'b1;
            req_we    = tbl[v].we;
            req_ba    = tbl[v].ba;
            req_row   = tbl[v].row;
            req_col   = tbl[v].col;
            @(posedge clk);
            #1 req_valid = 1'b0;
            a_act = -1; a_rw = -1; a_dn = -1; a_pre = -1; a_rdy = -1;
            a_act_ba = -1; a_act_addr = -1; a_rw_cmd = -1; a_rw_addr = -1;
            a_dwe = -1; a_pre_ba = -1; n_act = 0; n_dn = 0;
            c_dn_k = -1; c_pre_k = -1; c_rdy_k = -1;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (d_cmd == 4'b0011) begin
                    n_act++;
                    if (a_act < 0) begin
                        a_act = k; a_act_ba = int'(d_ba); a_act_addr = int'(d_addr);
                    end
                end
                if ((d_cmd == 4'b0101 || d_cmd == 4'b0100) && a_rw < 0) begin
                    a_rw = k; a_rw_cmd = int'(d_cmd); a_rw_addr = int'(d_addr);
                end
                if (d_done) begin
                    n_dn++;
                    if (a_dn < 0) begin
                        a_dn = k; a_dwe = int'(d_dwe);
                    end
                end
                if (d_cmd == 4'b0010 && a_pre < 0) begin
                    a_pre = k; a_pre_ba = int'(d_ba);
                end
                if (d_rdy && a_rdy < 0) a_rdy = k;
                if (c_done && c_dn_k < 0) c_dn_k = k;
                if (c_cmd == 4'b0010 && c_pre_k < 0) c_pre_k = k;
                if (c_rdy && c_rdy_k < 0) c_rdy_k = k;
            end
            chk($sformatf("v%0d_act_cyc", v), a_act, tbl[v].act);
            chk($sformatf("v%0d_act_ba", v), a_act_ba, 32'(tbl[v].ba));
            chk($sformatf("v%0d_act_addr", v), a_act_addr, 32'(tbl[v].row));
            chk($sformatf("v%0d_act_count", v), n_act, 1);
            chk($sformatf("v%0d_rw_cyc", v), a_rw, tbl[v].rw);
            chk($sformatf("v%0d_rw_cmd", v), a_rw_cmd, tbl[v].we ? 32'h4 : 32'h5);
            chk($sformatf("v%0d_rw_addr", v), a_rw_addr, tbl[v].rw_addr);
            chk($sformatf("v%0d_done_cyc", v), a_dn, tbl[v].dn);
            chk($sformatf("v%0d_done_we", v), a_dwe, 32'(tbl[v].we));
            chk($sformatf("v%0d_done_count", v), n_dn, 1);
            chk($sformatf("v%0d_pre_cyc", v), a_pre, tbl[v].pre);
            chk($sformatf("v%0d_pre_ba", v), a_pre_ba, 32'(tbl[v].ba));
            chk($sformatf("v%0d_rdy_cyc", v), a_rdy, tbl[v].rdy);
            chk($sformatf("v%0d_cl3_done", v), c_dn_k, tbl[v].c_dn);
            chk($sformatf("v%0d_cl3_pre", v), c_pre_k, tbl[v].c_pre);
            chk($sformatf("v%0d_cl3_rdy", v), c_rdy_k, tbl[v].c_rdy);
        end

        // Asynchronous reset two cycles after ACT
        do_reset();
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_ba    = 3'd2;
        req_row   = 14'h1A5;
        req_col   = 10'h040;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("mr_act_cmd", 32'(d_cmd), 32'h3);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("mr_pre_busy", 32'(d_busy), 1);
        chk("mr_pre_ba", 32'(d_ba), 2);
        rst_n = 1'b0;
        #1;
        check_reset_pins("mr_async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_rdy_after_rst", 32'(d_rdy), 1);
        n_act = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (d_cmd == 4'b0011) n_act++;
        end
        chk("mr_no_act_without_req", n_act, 0);
        req_valid = 1'b1;
        req_ba    = 3'd5;
        req_row   = 14'h0321;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("mr_new_act_cmd", 32'(d_cmd), 32'h3);
        chk("mr_new_act_ba", 32'(d_ba), 5);
        chk("mr_new_act_addr", 32'(d_addr), 32'h321);

        // Refresh priority (T_REFI=40) and saturation (T_REFI=10), req_valid held high
        rst_r_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_r_n = 1'b1;
        r40_viol = 0; r40_last = -1000; r10_gap_bad = 0; r10_idle = 0; r10_act_n = 0;
        idle_n = 0;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            if (f_cmd == 4'b0011) begin
                r40_act.push_back(k);
                if (k - r40_last <= 44) r40_viol++;
            end
            if (f_cmd == 4'b0001) begin
                r40_ref.push_back(k);
                r40_last = k;
            end
            if (g_cmd == 4'b0011) r10_act_n++;
            if (g_cmd == 4'b0001) begin
                if (r10_ref.size() > 0 && r10_idle != 1) r10_gap_bad++;
                r10_ref.push_back(k);
                r10_idle = 0;
            end else if (!g_busy) begin
                r10_idle++;
            end
            if (!f_busy) idle_n++;
        end
        chk("r40_act_count", r40_act.size(), 2);
        chk("r40_act0", (r40_act.size() > 0) ? r40_act[0] : -1, 2);
        chk("r40_act1", (r40_act.size() > 1) ? r40_act[1] : -1, 25);
        chk("r40_ref_count", r40_ref.size(), 3);
        chk("r40_ref0", (r40_ref.size() > 0) ? r40_ref[0] : -1, 48);
        chk("r40_ref1", (r40_ref.size() > 1) ? r40_ref[1] : -1, 93);
        chk("r40_act_in_rfc", r40_viol, 0);
        chk("r10_act_count", r10_act_n, 1);
        chk("r10_ref_count", r10_ref.size(), 3);
        chk("r10_ref0", (r10_ref.size() > 0) ? r10_ref[0] : -1, 25);
        chk("r10_ref1", (r10_ref.size() > 1) ? r10_ref[1] : -1, 70);
        chk("r10_ref2", (r10_ref.size() > 2) ? r10_ref[2] : -1, 115);
        chk("r10_one_idle_per_ref", r10_gap_bad, 0);
        chk("r40_idle_cycles", idle_n, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
